// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    CauseNone     = 2'b00,
    CauseIllegal  = 2'b01,
    CauseMisalign = 2'b10,
    CauseTimeout  = 2'b11
  } halt_cause_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_wdt.sv
// Fetch watchdog: counts FETCH cycles without ack and pulses expiry on the last allowed one.
module fetch_wdt (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [15:0] i_limit,
  output logic        o_expire
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = 16'd0;
    end else if (i_enable) begin
      count_d = count_q + 16'd1;
    end
  end

  // Expiry fires during the TIMEOUT-th ackless cycle so HALT follows on that edge.
  assign o_expire = i_enable && !i_clear && (count_q == i_limit - 16'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle RV32I fetch and PC sequencer: FETCH over req/ack, hold for EXEC, commit next PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic        o_inst_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_dec_vld,
  input  logic        i_stall,
  output logic        o_halt,
  output logic [1:0]  o_halt_cause,
  output logic [31:0] o_instret
);

  localparam logic [15:0] WdtLimit = 16'(TIMEOUT);

  fetch_state_e state_q, state_d;
  halt_cause_e  cause_q, cause_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  instret_q, instret_d;
  logic         halt_q, halt_d;
  logic [31:0]  next_pc;
  logic         wdt_clear, wdt_enable, wdt_expire;

  assign wdt_clear  = (state_q == FETCH) && i_imem_ack;
  assign wdt_enable = (state_q == FETCH) && !i_imem_ack;

  fetch_wdt u_wdt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (wdt_clear),
    .i_enable (wdt_enable),
    .i_limit  (WdtLimit),
    .o_expire (wdt_expire)
  );

  // Jump targets drop bit 0; bit 1 left set flags a misaligned target.
  assign next_pc = i_pc_sel ? {i_alu_data[31:1], 1'b0} : pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    halt_d    = halt_q;
    unique case (state_q)
      FETCH: begin
        if (i_imem_ack) begin
          inst_d  = i_imem_rdata;
          state_d = EXEC;
        end else if (wdt_expire) begin
          state_d = HALT;
          halt_d  = 1'b1;
          cause_d = CauseTimeout;
        end
      end
      EXEC: begin
        if (!i_stall) begin
          if (!i_dec_vld) begin
            state_d = HALT;
            halt_d  = 1'b1;
            cause_d = CauseIllegal;
          end else if (next_pc[1]) begin
            state_d = HALT;
            halt_d  = 1'b1;
            cause_d = CauseMisalign;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
            state_d   = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FETCH;
      cause_q   <= CauseNone;
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      instret_q <= 32'd0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      halt_q    <= halt_d;
    end
  end

  assign o_imem_req   = (state_q == FETCH);
  assign o_inst_vld   = (state_q == EXEC);
  assign o_imem_addr  = pc_q;
  assign o_pc         = pc_q;
  assign o_pc_four    = pc_q + 32'd4;
  assign o_inst       = inst_q;
  assign o_halt       = halt_q;
  assign o_halt_cause = cause_q;
  assign o_instret    = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal checks, then randomized traffic against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'hFFFF_FFF0;
  localparam int          TO  = 6;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_inst;
  logic        o_inst_vld;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        i_pc_sel;
  logic [31:0] i_alu_data;
  logic        i_dec_vld;
  logic        i_stall;
  logic        o_halt;
  logic [1:0]  o_halt_cause;
  logic [31:0] o_instret;

  fetch_unit #(
    .RESET_PC (RPC),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_inst       (o_inst),
    .o_inst_vld   (o_inst_vld),
    .o_pc         (o_pc),
    .o_pc_four    (o_pc_four),
    .i_pc_sel     (i_pc_sel),
    .i_alu_data   (i_alu_data),
    .i_dec_vld    (i_dec_vld),
    .i_stall      (i_stall),
    .o_halt       (o_halt),
    .o_halt_cause (o_halt_cause),
    .o_instret    (o_instret)
  );

  always #5 i_clk = ~i_clk;

  int nvec = 0;
  int nerr = 0;

  // Model: mode 0 = waiting on memory, 1 = instruction held for execute, 2 = stopped.
  int          m_mode;
  int          m_miss;
  logic [31:0] m_pc, m_inst, m_instret;
  logic        m_halt;
  logic [1:0]  m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_miss    = 0;
    m_pc      = RPC;
    m_inst    = NOPW;
    m_instret = 0;
    m_halt    = 1'b0;
    m_cause   = 2'b00;
  endtask

  task automatic model_stop(input logic [1:0] cause);
    m_mode  = 2;
    m_halt  = 1'b1;
    m_cause = cause;
  endtask

  task automatic model_edge(input logic ack, input logic [31:0] rd, input logic sel,
                            input logic [31:0] alu, input logic dec, input logic stall);
    logic [31:0] tgt;
    if (m_mode == 0) begin
      if (ack) begin
        m_inst = rd;
        m_mode = 1;
        m_miss = 0;
      end else begin
        m_miss++;
        if (m_miss == TO) model_stop(2'b11);
      end
    end else if (m_mode == 1 && !stall) begin
      tgt = sel ? (alu & ~32'd1) : m_pc + 32'd4;
      if (!dec) begin
        model_stop(2'b01);
      end else if (tgt % 4 != 0) begin
        model_stop(2'b10);
      end else begin
        m_pc      = tgt;
        m_instret = m_instret + 32'd1;
        m_mode    = 0;
      end
    end
  endtask

  // Compare DUT against the model mid-cycle, every cycle.
  always @(negedge i_clk) begin
    chk("imem_req", 32'(o_imem_req), 32'(m_mode == 0));
    chk("inst_vld", 32'(o_inst_vld), 32'(m_mode == 1));
    chk("imem_addr", o_imem_addr, m_pc);
    chk("pc", o_pc, m_pc);
    chk("pc_four", o_pc_four, m_pc + 32'd4);
    chk("inst", o_inst, m_inst);
    chk("halt", 32'(o_halt), 32'(m_halt));
    chk("halt_cause", 32'(o_halt_cause), 32'(m_cause));
    chk("instret", o_instret, m_instret);
  end

  task automatic step(input logic ack, input logic [31:0] rd, input logic sel,
                      input logic [31:0] alu, input logic dec, input logic stall);
    i_imem_ack   = ack;
    i_imem_rdata = rd;
    i_pc_sel     = sel;
    i_alu_data   = alu;
    i_dec_vld    = dec;
    i_stall      = stall;
    @(posedge i_clk);
    model_edge(ack, rd, sel, alu, dec, stall);
    #1;
  endtask

  // Called at posedge+1; checks that reset takes effect before any clock edge.
  task automatic do_reset();
    i_rst_n    = 1'b0;
    i_imem_ack = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", o_pc, RPC);
    chk("rst_req", 32'(o_imem_req), 32'd1);
    chk("rst_inst", o_inst, NOPW);
    chk("rst_instret", o_instret, 32'd0);
    chk("rst_halt", 32'(o_halt), 32'd0);
    chk("rst_vld", 32'(o_inst_vld), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    int hcnt;
    logic        r_ack, r_sel, r_dec, r_stall;
    logic [31:0] r_rd, r_alu;
    i_rst_n      = 1'b0;
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'd0;
    i_pc_sel     = 1'b0;
    i_alu_data   = 32'd0;
    i_dec_vld    = 1'b1;
    i_stall      = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    do_reset();

    // Same-cycle ack, sequential flow, PC wraps past 32'hFFFF_FFFC.
    step(1'b1, 32'h0050_0093, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("d_vld", 32'(o_inst_vld), 32'd1);
    chk("d_inst", o_inst, 32'h0050_0093);
    chk("d_pc0", o_pc, 32'hFFFF_FFF0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("d_addr1", o_imem_addr, 32'hFFFF_FFF4);
    chk("d_instret1", o_instret, 32'd1);
    step(1'b1, NOPW, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, NOPW, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("d_addr3", o_imem_addr, 32'hFFFF_FFFC);
    chk("d_four_wrap", o_pc_four, 32'd0);
    step(1'b1, NOPW, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("d_addr_wrap", o_imem_addr, 32'd0);
    chk("d_instret4", o_instret, 32'd4);

    // Ack latency 3, then jump with bit 0 set in the target.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      chk("d_lat_req", 32'(o_imem_req), 32'd1);
    end
    step(1'b1, 32'h0000_006F, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("d_lat_vld", 32'(o_inst_vld), 32'd1);
    step(1'b0, 32'd0, 1'b1, 32'h0000_0101, 1'b1, 1'b0);
    chk("d_jump", o_imem_addr, 32'h0000_0100);

    // Five stall cycles outrank an illegal decode, then the illegal halt.
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("d_stall_vld", 32'(o_inst_vld), 32'd1);
    end
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("d_ill_halt", 32'(o_halt), 32'd1);
    chk("d_ill_cause", 32'(o_halt_cause), 32'd1);
    chk("d_ill_pc", o_pc, 32'h0000_0100);
    do_reset();

    // Misaligned jump target.
    step(1'b1, 32'h0000_0063, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 32'h0000_0102, 1'b1, 1'b0);
    chk("d_mis_cause", 32'(o_halt_cause), 32'd2);
    chk("d_mis_pc", o_pc, RPC);
    chk("d_mis_instret", o_instret, 32'd0);
    step(1'b1, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("d_mis_req", 32'(o_imem_req), 32'd0);
    do_reset();

    // Timeout after exactly TO ackless cycles; a late ack changes nothing.
    for (int i = 0; i < TO - 1; i++) begin
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      chk("d_to_wait", 32'(o_halt), 32'd0);
    end
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("d_to_halt", 32'(o_halt), 32'd1);
    chk("d_to_cause", 32'(o_halt_cause), 32'd3);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("d_late_inst", o_inst, NOPW);
    do_reset();

    // Reset in the middle of a pending fetch.
    step(1'b1, NOPW, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    do_reset();

    hcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_mode == 2 && hcnt >= 3) begin
        hcnt = 0;
        do_reset();
      end else if (m_mode == 0 && $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r_ack   = (m_mode == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        r_rd    = $urandom;
        r_sel   = 1'($urandom_range(0, 1));
        r_alu   = $urandom;
        r_alu[1] = ($urandom_range(0, 15) == 0);
        r_dec   = ($urandom_range(0, 15) != 0);
        r_stall = ($urandom_range(0, 3) == 0);
        step(r_ack, r_rd, r_sel, r_alu, r_dec, r_stall);
        if (m_mode == 2) hcnt++;
      end
    end

    @(posedge i_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
